// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: switch synchronizer and debouncer feeding a shared
// seven-segment decoder that is time-multiplexed across two digits.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   SHOW_ONES | ones digit lit for SCAN_CYCLES; frame snapshot taken on entry
//   BLANK_A   | all digits off for BLANK_CYCLES (ones -> tens gap)
//   SHOW_TENS | tens digit lit for SCAN_CYCLES (or blanked when leading zero)
//   BLANK_B   | all digits off for BLANK_CYCLES (tens -> ones gap)
module display_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_CYCLES     = 8,
  parameter int BLANK_CYCLES    = 1,
  parameter bit LZ_BLANK        = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] value,
  output logic [4:0] bcd,
  output logic       update,
  output logic [6:0] seg,
  output logic [1:0] digit_sel
);

  localparam int DBW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_MAX = (SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES;
  localparam int SCW    = (SC_MAX > 1) ? $clog2(SC_MAX) : 1;

  localparam logic [DBW-1:0] DB_TC    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SCAN_TC  = SCW'(SCAN_CYCLES - 1);
  localparam logic [SCW-1:0] BLANK_TC = SCW'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    SHOW_ONES = 2'd0,
    BLANK_A   = 2'd1,
    SHOW_TENS = 2'd2,
    BLANK_B   = 2'd3
  } state_t;

  logic [3:0]     sync1, sync2;
  logic [3:0]     cand;
  logic [DBW-1:0] db_cnt;

  state_t         state, state_nx;
  logic [SCW-1:0] scan_cnt, scan_cnt_nx;
  logic [4:0]     snap;

  logic [6:0]     seg_nx;
  logic [1:0]     digit_sel_nx;

  function automatic logic [4:0] to_bcd(input logic [3:0] v);
    logic [4:0] r;
    if (v >= 4'd10) r = {1'b1, v - 4'd10};
    else            r = {1'b0, v};
    return r;
  endfunction

  // Active-low gfedcba patterns; anything outside 0-9 is dark.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Debounce: candidate must stay put for DEBOUNCE_CYCLES before it becomes value.
  // The accept decision uses the registered count/candidate only, so a fresh
  // mismatch on the same edge cannot cancel a candidate that already qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= '0;
      db_cnt <= '0;
      value  <= '0;
      bcd    <= '0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= '0;
      end else if (db_cnt != DB_TC) begin
        db_cnt <= db_cnt + DBW'(1);
      end
      if ((db_cnt == DB_TC) && (cand != value)) begin
        value  <= cand;
        bcd    <= to_bcd(cand);
        update <= 1'b1;
      end
    end
  end

  // Scan FSM state and dwell counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHOW_ONES;
      scan_cnt <= '0;
    end else begin
      state    <= state_nx;
      scan_cnt <= scan_cnt_nx;
    end
  end

  // Scan FSM next state: advance when the dwell counter reaches this state's length.
  always_comb begin
    logic [SCW-1:0] tc;
    state_nx    = state;
    scan_cnt_nx = scan_cnt + SCW'(1);
    tc          = ((state == SHOW_ONES) || (state == SHOW_TENS)) ? SCAN_TC : BLANK_TC;
    if (scan_cnt == tc) begin
      scan_cnt_nx = '0;
      case (state)
        SHOW_ONES: state_nx = BLANK_A;
        BLANK_A:   state_nx = SHOW_TENS;
        SHOW_TENS: state_nx = BLANK_B;
        BLANK_B:   state_nx = SHOW_ONES;
        default:   state_nx = SHOW_ONES;
      endcase
    end
  end

  // Frame snapshot: latch bcd on entry to SHOW_ONES so both digits agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if ((state == BLANK_B) && (state_nx == SHOW_ONES)) begin
      snap <= bcd;
    end
  end

  // Digit drive for the current state, taken from the frame snapshot.
  always_comb begin
    seg_nx       = SEG_OFF;
    digit_sel_nx = 2'b00;
    case (state)
      SHOW_ONES: begin
        seg_nx       = decode7(snap[3:0]);
        digit_sel_nx = 2'b01;
      end
      SHOW_TENS: begin
        if (!(LZ_BLANK && !snap[4])) begin
          seg_nx       = decode7({3'b000, snap[4]});
          digit_sel_nx = 2'b10;
        end
      end
      default: begin
        seg_nx       = SEG_OFF;
        digit_sel_nx = 2'b00;
      end
    endcase
  end

  // Register the digit drive so segment and enable lines change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg       <= SEG_OFF;
      digit_sel <= 2'b00;
    end else begin
      seg       <= seg_nx;
      digit_sel <= digit_sel_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: directed scenarios plus random switch
// activity, every cycle compared against a sample-history reference model.
module tb_display_scan_ctrl;

  localparam int DEB   = 16;
  localparam int SCAN  = 8;
  localparam int BLANK = 1;
  localparam int PER   = 2 * (SCAN + BLANK);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] value;
  logic [4:0] bcd;
  logic       update;
  logic [6:0] seg;
  logic [1:0] digit_sel;

  display_scan_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES(SCAN),
    .BLANK_CYCLES(BLANK),
    .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .value(value),
    .bcd(bcd),
    .update(update),
    .seg(seg),
    .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Reference model state.
  logic [3:0] hist [$];
  int         m_k;
  logic [3:0] m_value;
  logic [4:0] m_bcd;
  logic [4:0] m_snap;
  logic       m_update;
  logic [6:0] m_seg;
  logic [1:0] m_dsel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] bcd_of(input int v);
    return {1'(v / 10), 4'(v % 10)};
  endfunction

  // Model one clock edge from the inputs seen at that edge.
  task automatic model_edge();
    int  pos;
    int  n;
    bit  stable;
    if (rst) begin
      hist     = '{4'd0, 4'd0, 4'd0};
      m_k      = 0;
      m_value  = '0;
      m_bcd    = '0;
      m_snap   = '0;
      m_update = 1'b0;
      m_seg    = 7'h7F;
      m_dsel   = 2'b00;
      return;
    end
    hist.push_back(sw);
    if (hist.size() > DEB + 3) void'(hist.pop_front());
    m_k++;
    pos = (m_k - 1) % PER;
    m_seg  = 7'h7F;
    m_dsel = 2'b00;
    if (pos < SCAN) begin
      m_dsel = 2'b01;
      m_seg  = seg_tab[int'(m_snap[3:0])];
    end else if (pos >= SCAN + BLANK && pos < 2 * SCAN + BLANK && m_snap[4]) begin
      m_dsel = 2'b10;
      m_seg  = seg_tab[1];
    end
    if (m_k % PER == 0) m_snap = m_bcd;
    // value follows a 3-cycle-delayed sample once it has been seen DEB times in a row
    m_update = 1'b0;
    n = hist.size();
    if (n >= DEB + 3) begin
      stable = 1'b1;
      for (int i = n - 3 - DEB; i <= n - 4; i++)
        if (hist[i] != hist[n-4]) stable = 1'b0;
      if (stable && hist[n-4] != m_value) begin
        m_value  = hist[n-4];
        m_bcd    = bcd_of(int'(hist[n-4]));
        m_update = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (update === 1'b1) upd_cnt++;
    check("value", 32'(value), 32'(m_value));
    check("bcd", 32'(bcd), 32'(m_bcd));
    check("update", 32'(update), 32'(m_update));
    check("seg", 32'(seg), 32'(m_seg));
    check("digit_sel", 32'(digit_sel), 32'(m_dsel));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while ((m_k % PER) != p && guard < 2 * PER) begin
      step();
      guard++;
    end
    check("wait_pos_timeout", 32'(m_k % PER), 32'(p));
  endtask

  initial begin
    int lat;
    int u0;
    int n01, n10, n00, n11;
    rst = 1'b1;
    sw  = 4'b0000;
    steps(3);
    check("rst_value", 32'(value), 32'd0);
    check("rst_seg", 32'(seg), 32'h7F);
    rst = 1'b0;
    step();
    check("first_ones_seg", 32'(seg), 32'(7'b1000000));
    check("first_ones_sel", 32'(digit_sel), 32'(2'b01));

    // clean change to 10
    sw  = 4'b1010;
    lat = 0;
    do begin
      step();
      lat++;
    end while (update !== 1'b1 && lat < 40);
    check("clean_latency", 32'(lat), 32'd19);
    check("clean_bcd", 32'(bcd), 32'(5'b10000));
    steps(40);

    // bounce toward 7
    sw = 4'b0000;
    steps(30);
    u0 = upd_cnt;
    sw = 4'b0111; steps(5);
    sw = 4'b0000; steps(5);
    sw = 4'b0111; steps(40);
    check("bounce_updates", 32'(upd_cnt - u0), 32'd1);
    check("bounce_value", 32'(value), 32'd7);

    // scan pattern with a two-digit value
    sw = 4'd12;
    steps(60);
    n01 = 0; n10 = 0; n00 = 0; n11 = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      case (digit_sel)
        2'b01:   n01++;
        2'b10:   n10++;
        2'b00:   n00++;
        default: n11++;
      endcase
    end
    check("scan_ones_cycles", 32'(n01), 32'd16);
    check("scan_tens_cycles", 32'(n10), 32'd16);
    check("scan_blank_cycles", 32'(n00), 32'd4);
    check("scan_both_on", 32'(n11), 32'd0);

    // value 3 -> 15 landing during SHOW_TENS
    sw = 4'd3;
    steps(60);
    wait_pos(12);
    sw = 4'd15;
    steps(3 * PER);
    check("midframe_value", 32'(value), 32'd15);

    // reset during SHOW_TENS with value 12
    sw = 4'd12;
    steps(60);
    wait_pos(12);
    rst = 1'b1;
    step();
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_sel", 32'(digit_sel), 32'd0);
    check("midrst_update", 32'(update), 32'd0);
    rst = 1'b0;
    steps(40);

    // random switch activity with occasional resets
    for (int r = 0; r < 250; r++) begin
      if ($urandom_range(39, 0) == 0) begin
        rst = 1'b1;
        steps($urandom_range(3, 1));
        rst = 1'b0;
      end else begin
        sw = 4'($urandom);
        steps($urandom_range(30, 1));
      end
    end
    steps(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencer for the board's two-digit seven-segment output path. It synchronizes and debounces the four input switches into a stable 4-bit value and splits that value into 5-bit BCD (tens bit, ones nibble). It then time-multiplexes one internal 7-segment decoder across the two digits, with a blanking gap between digits. It replaces the static two-decoder path when the board drives digits through shared segment lines and per-digit enables.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required before accepting a new switch value (board build: 500000)
SCAN_CYCLES, 8, cycles each digit is lit per frame (>=1)
BLANK_CYCLES, 1, cycles with all digits off between digits (>=1)
LZ_BLANK, 1, 1 = blank tens digit when it is 0

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
sw  in  4  raw switches {bit1,bit2,bit3,bit4}, sw[3]=MSB, asynchronous to clk
value  out  4  debounced switch value
bcd  out  5  {tens, ones[3:0]} of value
update  out  1  one-cycle pulse when value changes
seg  out  7  {g,f,e,d,c,b,a}, active-low (0 = segment lit)
digit_sel  out  2  digit enable, active-high; [0]=ones, [1]=tens; at most one bit set

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on rising clk.
- Reset values: value=0, bcd=0, update=0, sync/candidate regs=0, debounce count=0, FSM=SHOW_ONES, scan count=0, frame snapshot=0, seg=7'h7F, digit_sel=2'b00. All outputs are registered.
- Synchronizer: two flops on sw. Debouncer compares the synchronized value to the candidate. On mismatch: candidate<=sync, count<=0. On match: count increments, saturating at DEBOUNCE_CYCLES-1. On the cycle count==DEBOUNCE_CYCLES-1 and candidate!=value: value<=candidate, update=1 for exactly that cycle.
- Latency: a clean sw change appears on value 2+DEBOUNCE_CYCLES+1 cycles after the sw edge (2 sync, DEBOUNCE_CYCLES to reach terminal count, 1 register). Any bounce shorter than DEBOUNCE_CYCLES never reaches value.
- BCD: if value>=10 then tens=1, ones=value-10; else tens=0, ones=value. bcd updates in the same cycle as value.
- FSM states: SHOW_ONES -> BLANK_A -> SHOW_TENS -> BLANK_B -> SHOW_ONES.
  - Each SHOW state lasts SCAN_CYCLES cycles; each BLANK state lasts BLANK_CYCLES cycles.
  - Scan counter resets to 0 on every state change.
  - Frame period = 2*(SCAN_CYCLES+BLANK_CYCLES).
- Snapshot: bcd is copied into the frame snapshot on every entry into SHOW_ONES, and on reset. Both digits of one frame come from the same snapshot, so no tearing. A value change mid-frame is shown from the next SHOW_ONES.
- Outputs, one cycle after the FSM state (registered):
  - SHOW_ONES: digit_sel=01, seg=decode(ones).
  - SHOW_TENS: digit_sel=10, seg=decode(tens), except when LZ_BLANK=1 and tens=0, then digit_sel=00 and seg=7'h7F.
  - BLANK states: digit_sel=00, seg=7'h7F.
- Decoder codes (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Ones is always 0-9; any other input decodes to 7'h7F.
- Reset asserted mid-frame or mid-debounce: all state returns to reset values on the next edge. No update pulse is generated by reset.
- sw changes while update is high are handled normally. A new candidate restarts the count, with no dropped or duplicated pulse.

Test Plan:
- Reset: hold rst 3 cycles with sw=4'b0000 -> value=0, bcd=0, update=0. First ones slot shows seg=7'b1000000, digit_sel=01. Tens slot is blanked (digit_sel=00, seg=7F) with LZ_BLANK=1.
- Clean change: sw=4'b1010 held -> value=10 and bcd=5'b10000 exactly 19 cycles after the edge (defaults). update high for 1 cycle. Next frame: ones slot seg=1000000, tens slot digit_sel=10, seg=1111001.
- Bounce: sw toggles 0000->0111->0000->0111 with 5-cycle gaps, then holds 0111 -> no update during the bounce. Single update to value=7 only after 16 stable cycles; display shows 7 (1111000) with the tens digit blanked.
- Scan timing (defaults): measure digit_sel over 36 cycles -> pattern 01 x8, 00 x1, 10 x8, 00 x1, repeating with period 18. digit_sel is never 11.
- Mid-frame change: value changes 3->15 during SHOW_TENS -> the current frame finishes showing 3. The next SHOW_ONES shows 5 (0010010), and its tens slot shows 1.
- Reset mid-operation: assert rst during SHOW_TENS with value=12 -> the next cycle gives value=0, seg=7F, digit_sel=00, update=0. The debouncer restarts from count 0.
